load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the pipeline MEM stage and the word-addressed data memory (async read, sync write, word index = addr[31:2]).
- Converts RV32I lb/lh/lw/lbu/lhu/sb/sh/sw into word accesses. Loads are byte-lane selected and sign/zero-extended; sub-word stores use a two-cycle read-modify-write; misaligned and illegal accesses are flagged.
- Registered response one cycle after a request is consumed.

Parameters:
- ADDR_W, 32, width of request and memory address.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  MEM stage presents an access.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  combinational; request not consumed this cycle, so the pipeline holds it.
- resp_valid  out  1  registered one-cycle pulse per consumed request.
- resp_rdata  out  32  registered extended load data; 0 for stores and errors.
- resp_err  out  1  registered, with resp_valid; misaligned or illegal access.
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  full word to write.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  combinational memory read word at mem_addr.

Behaviour:
- Consumed = req_valid && !stall at posedge clk. Exactly one resp_valid pulse follows, in the next cycle.
- FSM states: IDLE, RMW_WR.
- Error classification in IDLE, req_valid=1:
  - Misaligned: w with addr[1:0]!=0; h/hu with addr[0]=1.
  - Illegal: funct3 in {011,110,111}; store with funct3 100 or 101.
  - Either case: mem_we=0, consumed immediately, resp_err=1, resp_rdata=0.
- Load (IDLE, no error):
  - mem_addr from req_addr; consumed same cycle; stall=0.
  - Lane select: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16].
  - b/h sign-extend; bu/hu zero-extend.
  - Result registered into resp_rdata.
- sw (IDLE, aligned): mem_we=1, mem_wdata=req_wdata this cycle; consumed; stall=0.
- sb/sh (IDLE, aligned):
  - Cycle 1 (IDLE): stall=1, mem_we=0, mem_addr from req_addr. Latch mem_rdata, word address, offset, size and wdata. Go to RMW_WR.
  - Cycle 2 (RMW_WR): stall=0, mem_we=1, mem_addr=latched address. mem_wdata = latched word with the target lane replaced by req_wdata[7:0] (sb) or [15:0] (sh). Other lanes unchanged.
  - The held request is consumed in cycle 2; the unit uses latched values, not live inputs. Go to IDLE.
- Back-to-back: a new request may be presented the cycle after consumption. No bubble except the RMW stall cycle.
- req_valid=0 in IDLE: mem_we=0, stall=0, no response.
- Reset (rst_n=0 at posedge):
  - State goes to IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we is forced 0 combinationally while rst_n=0, including mid-RMW. An aborted RMW writes nothing.
  - stall=0 while rst_n=0.
- mem_we never asserts in two consecutive cycles for one request. No write ever occurs for an errored request.

Test Plan:
- Preload word 0x8000_00F0 at 0x10. lb @0x10 gives resp_rdata 0xFFFF_FFF0. lbu @0x10 gives 0x0000_00F0. lhu @0x12 gives 0x0000_8000. lh @0x12 gives 0xFFFF_8000. Each resp_valid comes exactly 1 cycle after the request; stall stays 0.
- Preload 0x1122_3344 at 0x20. sb wdata=0xAB @0x21 gives stall=1 for one cycle. Next cycle mem_we=1 with mem_wdata 0x1122_AB44. Then lw @0x20 returns 0x1122_AB44.
- sh wdata=0xBEEF @0x22 over 0x1122_3344 writes 0xBEEF_3344. sw 0xDEAD_BEEF @0x24 writes in the request cycle with no stall.
- lw @0x22, lh @0x13 and sh @0x15 each give resp_err=1, resp_rdata=0, mem_we never asserted, memory unchanged. funct3=011 load and funct3=100 store also give resp_err=1.
- Issue sb @0x21, then drive rst_n=0 in the RMW_WR cycle. mem_we stays 0, memory keeps 0x1122_3344, and after reset resp_valid=0 and the FSM is in IDLE.
- Back-to-back stream lw, sw, lb, sh, lw (all aligned) completes in 6 cycles with exactly one stall cycle. resp_valid pulses exactly 5 times with correct data.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response bundle for the load/store unit.
// The pipeline drives the master side, and the LSU drives the slave side.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  stall, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output stall, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed memory (async read, sync write).
// It selects load lanes and extends them, and it does sub-word stores as read-modify-write.
//
// state  | meaning
// IDLE   | accept a request; loads, sw and errors complete here
// RMW_WR | write back the merged word of a latched sb/sh
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t state, state_nxt;

  logic [ADDR_W-3:0] rmw_waddr;
  logic [31:0]       rmw_word;
  logic [1:0]        rmw_off;
  logic              rmw_half;
  logic [15:0]       rmw_data;

  logic        misaligned, illegal, req_err, sub_store;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, merged;
  logic        stall_c, we_c, consume, latch;
  logic [31:0] rsp_data_nxt;
  logic        rsp_err_nxt;

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (bus.req_funct3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = bus.req_addr[0];
      F3_W:        misaligned = |bus.req_addr[1:0];
      default:     illegal    = 1'b1;
    endcase
    if (bus.req_we && (bus.req_funct3 == F3_BU || bus.req_funct3 == F3_HU))
      illegal = 1'b1;
  end

  assign req_err   = misaligned || illegal;
  assign sub_store = bus.req_we && (bus.req_funct3 == F3_B || bus.req_funct3 == F3_H);

  assign ld_byte = mem_rdata[{bus.req_addr[1:0], 3'b000} +: 8];
  assign ld_half = mem_rdata[{bus.req_addr[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = '0;
    case (bus.req_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = mem_rdata;
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    merged = rmw_word;
    if (rmw_half)
      merged[{rmw_off[1], 4'b0000} +: 16] = rmw_data;
    else
      merged[{rmw_off, 3'b000} +: 8] = rmw_data[7:0];
  end

  always_comb begin
    state_nxt    = state;
    stall_c      = 1'b0;
    we_c         = 1'b0;
    consume      = 1'b0;
    latch        = 1'b0;
    rsp_data_nxt = '0;
    rsp_err_nxt  = 1'b0;
    mem_addr     = {bus.req_addr[ADDR_W-1:2], 2'b00};
    mem_wdata    = bus.req_wdata;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_err) begin
            consume     = 1'b1;
            rsp_err_nxt = 1'b1;
          end else if (!bus.req_we) begin
            consume      = 1'b1;
            rsp_data_nxt = ld_data;
          end else if (sub_store) begin
            stall_c   = 1'b1;
            latch     = 1'b1;
            state_nxt = RMW_WR;
          end else begin
            we_c    = 1'b1;
            consume = 1'b1;
          end
        end
      end
      RMW_WR: begin
        // The write-back uses only latched values. The live request is not used here.
        mem_addr  = {rmw_waddr, 2'b00};
        mem_wdata = merged;
        we_c      = 1'b1;
        consume   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gating the write with rst_n means a reset in RMW_WR cannot commit a half-done store.
  assign mem_we    = we_c && rst_n;
  assign bus.stall = stall_c && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.resp_valid <= consume;
      bus.resp_rdata <= rsp_data_nxt;
      bus.resp_err   <= rsp_err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      rmw_waddr <= bus.req_addr[ADDR_W-1:2];
      rmw_word  <= mem_rdata;
      rmw_off   <= bus.req_addr[1:0];
      rmw_half  <= (bus.req_funct3 == F3_H);
      rmw_data  <= bus.req_wdata[15:0];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table for single-cycle accesses,
// plus hand sequences for read-modify-write, an aborted store and a back-to-back stream.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  int          wr_cnt = 0;
  logic        addr_bad = 1'b0;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk)
    if (mem_we && (mem_addr[31:8] != 24'd0 || mem_addr[1:0] != 2'b00)) addr_bad = 1'b1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_we;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee, input logic ew);
    vec_t v;
    v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_we = ew;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_data = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    int w0;
    @(negedge clk);
    drive(v.we, v.f3, v.addr, v.wdata);
    w0 = wr_cnt;
    #1;
    check({v.name, " stall"}, 32'(bus.stall), 32'd0);
    check({v.name, " mem_we"}, 32'(mem_we), 32'(v.exp_we));
    check({v.name, " early resp_valid"}, 32'(bus.resp_valid), 32'd0);
    if (v.exp_we) check({v.name, " mem_wdata"}, mem_wdata, v.wdata);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({v.name, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({v.name, " resp_rdata"}, bus.resp_rdata, v.exp_rdata);
    check({v.name, " resp_err"}, 32'(bus.resp_err), 32'(v.exp_err));
    check({v.name, " writes"}, 32'(wr_cnt - w0), 32'(v.exp_we));
    @(negedge clk);
    check({v.name, " resp pulse"}, 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic rmw_store(input string n, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_word);
    @(negedge clk);
    drive(1'b1, f3, a, wd);
    #1;
    check({n, " c1 stall"}, 32'(bus.stall), 32'd1);
    check({n, " c1 mem_we"}, 32'(mem_we), 32'd0);
    @(negedge clk);
    #1;
    check({n, " c2 stall"}, 32'(bus.stall), 32'd0);
    check({n, " c2 mem_we"}, 32'(mem_we), 32'd1);
    check({n, " c2 mem_wdata"}, mem_wdata, exp_word);
    check({n, " c2 mem_addr"}, mem_addr, {a[31:2], 2'b00});
    check({n, " c2 resp_valid"}, 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({n, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({n, " resp_err"}, 32'(bus.resp_err), 32'd0);
    check({n, " resp_rdata"}, bus.resp_rdata, 32'd0);
    check({n, " mem word"}, mem[a[7:2]], exp_word);
    check({n, " no 2nd write"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    int w0;
    int k, stalls, cyc, nresp;
    logic        s_we [5];
    logic [2:0]  s_f3 [5];
    logic [31:0] s_addr [5];
    logic [31:0] s_wd [5];
    logic [31:0] s_exp [5];

    rst_n = 1'b0;
    drive(1'b1, 3'b010, 32'h10, 32'h5555_5555);
    @(negedge clk);
    #1;
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_rdata", bus.resp_rdata, 32'd0);
    check("rst resp_err", 32'(bus.resp_err), 32'd0);
    check("rst sw stall", 32'(bus.stall), 32'd0);
    check("rst sw mem_we", 32'(mem_we), 32'd0);
    drive(1'b1, 3'b000, 32'h21, 32'hAB);
    #1;
    check("rst sb stall", 32'(bus.stall), 32'd0);
    check("rst sb mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("rst resp_valid 2", 32'(bus.resp_valid), 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;

    preload(6'd4, 32'h8000_00F0);
    preload(6'd8, 32'h1122_3344);

    add("lb 0x10",   1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFF0, 1'b0, 1'b0);
    add("lbu 0x10",  1'b0, 3'b100, 32'h10, 32'h0, 32'h0000_00F0, 1'b0, 1'b0);
    add("lhu 0x12",  1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8000, 1'b0, 1'b0);
    add("lh 0x12",   1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8000, 1'b0, 1'b0);
    add("lbu 0x13",  1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
    add("lw 0x20",   1'b0, 3'b010, 32'h20, 32'h0, 32'h1122_3344, 1'b0, 1'b0);
    add("lh 0x20",   1'b0, 3'b001, 32'h20, 32'h0, 32'h0000_3344, 1'b0, 1'b0);
    add("lw 0x22",   1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1'b0);
    add("lh 0x13",   1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0);
    add("sh 0x15",   1'b1, 3'b001, 32'h15, 32'hFFFF, 32'h0, 1'b1, 1'b0);
    add("sw 0x21",   1'b1, 3'b010, 32'h21, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    add("ld f3=011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0);
    add("ld f3=110", 1'b0, 3'b110, 32'h20, 32'h0, 32'h0, 1'b1, 1'b0);
    add("st f3=100", 1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    add("st f3=101", 1'b1, 3'b101, 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    add("sw 0x24",   1'b1, 3'b010, 32'h24, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    add("lw 0x24",   1'b0, 3'b010, 32'h24, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    add("lb 0x25",   1'b0, 3'b000, 32'h25, 32'h0, 32'hFFFF_FFBE, 1'b0, 1'b0);
    add("lbu 0x27",  1'b0, 3'b100, 32'h27, 32'h0, 32'h0000_00DE, 1'b0, 1'b0);
    add("lhu 0x24",  1'b0, 3'b101, 32'h24, 32'h0, 32'h0000_BEEF, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    check("mem 0x20 after errors", mem[8], 32'h1122_3344);

    rmw_store("sb 0x21", 3'b000, 32'h21, 32'hAB, 32'h1122_AB44);
    add("lw after sb", 1'b0, 3'b010, 32'h20, 32'h0, 32'h1122_AB44, 1'b0, 1'b0);
    apply(vecs[vecs.size()-1]);
    preload(6'd8, 32'h1122_3344);
    rmw_store("sh 0x22", 3'b001, 32'h22, 32'h0000_BEEF, 32'hBEEF_3344);
    preload(6'd8, 32'h1122_3344);
    rmw_store("sb 0x23", 3'b000, 32'h23, 32'hFFFF_FF5A, 32'h5A22_3344);

    // A reset that arrives in the write-back cycle must drop the store.
    preload(6'd8, 32'h1122_3344);
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h21, 32'hAB);
    #1;
    check("abort c1 stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    w0 = wr_cnt;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("abort mem_we", 32'(mem_we), 32'd0);
    check("abort stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    check("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort resp_valid 2", 32'(bus.resp_valid), 32'd0);
    check("abort mem word", mem[8], 32'h1122_3344);
    check("abort writes", 32'(wr_cnt - w0), 32'd0);
    add("lbu after abort", 1'b0, 3'b100, 32'h20, 32'h0, 32'h0000_0044, 1'b0, 1'b0);
    apply(vecs[vecs.size()-1]);

    // The back-to-back stream holds each request until it is accepted.
    preload(6'd10, 32'h0);
    s_we[0] = 1'b0; s_f3[0] = 3'b010; s_addr[0] = 32'h20; s_wd[0] = 32'h0;         s_exp[0] = 32'h1122_3344;
    s_we[1] = 1'b1; s_f3[1] = 3'b010; s_addr[1] = 32'h28; s_wd[1] = 32'hCAFE_F00D; s_exp[1] = 32'h0;
    s_we[2] = 1'b0; s_f3[2] = 3'b000; s_addr[2] = 32'h10; s_wd[2] = 32'h0;         s_exp[2] = 32'hFFFF_FFF0;
    s_we[3] = 1'b1; s_f3[3] = 3'b001; s_addr[3] = 32'h2A; s_wd[3] = 32'h0000_1234; s_exp[3] = 32'h0;
    s_we[4] = 1'b0; s_f3[4] = 3'b010; s_addr[4] = 32'h28; s_wd[4] = 32'h0;         s_exp[4] = 32'h1234_F00D;
    k = 0; stalls = 0; cyc = 0; nresp = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (nresp < 5) begin
          check($sformatf("stream resp %0d rdata", nresp), bus.resp_rdata, s_exp[nresp]);
          check($sformatf("stream resp %0d err", nresp), 32'(bus.resp_err), 32'd0);
        end
        nresp++;
      end
      if (k < 5) begin
        drive(s_we[k], s_f3[k], s_addr[k], s_wd[k]);
        cyc++;
        #1;
        if (bus.stall) stalls++;
        else k++;
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    check("stream cycles", 32'(cyc), 32'd6);
    check("stream stalls", 32'(stalls), 32'd1);
    check("stream responses", 32'(nresp), 32'd5);
    check("stream mem 0x28", mem[10], 32'h1234_F00D);
    check("write address aligned/in range", 32'(addr_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
